urv_decode_sb: RTL and testbench

//  Parametrised decode stage for the uRV pipeline: sits between fetch and execute-1, same slot as the current decoder.
//  A per-register scoreboard of pending-latency counters replaces the fixed load/shift/mul bubble logic.

---
 rtl/urv_decode_sb.sv | 230 +++++++++++++++++++++++
 tb/tb_urv_decode_sb.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/urv_decode_sb.sv
// urv_decode_sb: uRV decode stage; a per-register pending-latency scoreboard inserts bubbles for slow producers.
// Latency: 1 cycle f_* -> x_*; rf_rs*_o and d_stall_req_o are combinational.
// Backpressure: d_stall_i freezes all state; a scoreboard hazard raises d_stall_req_o and issues bubbles.
// Optional feature: define URV_DECODE_MULDIV_EN to decode DIV/DIVU/REM/REMU (otherwise they are undefined).
module urv_decode_sb #(
    parameter int LOAD_LAT  = 2,
    parameter int SHIFT_LAT = 1,
    parameter int MUL_LAT   = 1,
    parameter int DIV_LAT   = 4,
    parameter int CNT_W     = 3
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        d_stall_i,
    input  logic        d_kill_i,
    output logic        d_stall_req_o,
    input  logic [31:0] f_ir_i,
    input  logic [31:0] f_pc_i,
    input  logic        f_valid_i,
    input  logic        f_is_compressed_i,
    output logic [4:0]  rf_rs1_o,
    output logic [4:0]  rf_rs2_o,
    output logic        x_valid_o,
    output logic [31:0] x_pc_o,
    output logic [4:0]  x_rs1_o,
    output logic [4:0]  x_rs2_o,
    output logic [4:0]  x_rd_o,
    output logic [4:0]  x_opcode_o,
    output logic [2:0]  x_fun_o,
    output logic [31:0] x_imm_o,
    output logic        x_rd_write_o,
    output logic        x_is_load_o,
    output logic        x_is_store_o,
    output logic        x_is_undef_o,
    output logic [2:0]  x_rd_source_o,
    output logic [31:0] sb_busy_o
);
    localparam logic [4:0] OPC_LOAD = 5'b00000, OPC_OP_IMM = 5'b00100, OPC_AUIPC = 5'b00101,
                           OPC_STORE = 5'b01000, OPC_OP = 5'b01100, OPC_LUI = 5'b01101,
                           OPC_BRANCH = 5'b11000, OPC_JALR = 5'b11001, OPC_JAL = 5'b11011,
                           OPC_SYSTEM = 5'b11100;
    localparam logic [2:0] SRC_ALU = 3'd0, SRC_SHIFTER = 3'd1, SRC_MULTIPLY = 3'd2,
                           SRC_CSR = 3'd3, SRC_DIVIDE = 3'd4;

`ifdef URV_DECODE_MULDIV_EN
    localparam logic MULDIV_EN = 1'b1;
`else
    localparam logic MULDIV_EN = 1'b0;
`endif

    localparam logic [CNT_W-1:0] C_LOAD  = CNT_W'(LOAD_LAT);
    localparam logic [CNT_W-1:0] C_SHIFT = CNT_W'(SHIFT_LAT);
    localparam logic [CNT_W-1:0] C_MUL   = CNT_W'(MUL_LAT);
    localparam logic [CNT_W-1:0] C_DIV   = CNT_W'(DIV_LAT);

    // Every latency has to fit in a counter, or the scoreboard would under-count.
    generate
        if (LOAD_LAT >= (1 << CNT_W) || SHIFT_LAT >= (1 << CNT_W) ||
            MUL_LAT >= (1 << CNT_W) || DIV_LAT >= (1 << CNT_W)) begin : g_lat_check
            $error("urv_decode_sb: a producer latency does not fit in CNT_W bits");
        end
    endgenerate

    logic [CNT_W-1:0] r_cnt [32];

    logic        r_x_valid, r_x_rd_write, r_x_is_load, r_x_is_store, r_x_is_undef;
    logic [31:0] r_x_pc, r_x_imm;
    logic [4:0]  r_x_rs1, r_x_rs2, r_x_rd, r_x_opcode;
    logic [2:0]  r_x_fun, r_x_rd_source;

    logic [4:0]  w_opc, w_rs1, w_rs2, w_rd;
    logic [2:0]  w_fun3;
    logic        w_load, w_opimm, w_auipc, w_store, w_op, w_lui, w_branch, w_jalr, w_jal, w_system;
    logic        w_is_mul, w_is_div, w_is_shift, w_div_undef, w_known, w_rd_nz;
    logic        w_rd_write, w_sb_write, w_use1, w_use2, w_hazard, w_issue, w_cnt_load;
    logic [CNT_W-1:0] w_lat;
    logic [2:0]  w_src;
    logic [31:0] w_imm, w_sb_busy;
    logic        w_unused;

    assign w_opc  = f_ir_i[6:2];
    assign w_rd   = f_ir_i[11:7];
    assign w_fun3 = f_ir_i[14:12];
    assign w_rs1  = f_ir_i[19:15];
    assign w_rs2  = f_ir_i[24:20];

    assign w_load   = (w_opc == OPC_LOAD);
    assign w_opimm  = (w_opc == OPC_OP_IMM);
    assign w_auipc  = (w_opc == OPC_AUIPC);
    assign w_store  = (w_opc == OPC_STORE);
    assign w_op     = (w_opc == OPC_OP);
    assign w_lui    = (w_opc == OPC_LUI);
    assign w_branch = (w_opc == OPC_BRANCH);
    assign w_jalr   = (w_opc == OPC_JALR);
    assign w_jal    = (w_opc == OPC_JAL);
    assign w_system = (w_opc == OPC_SYSTEM);
    assign w_known  = w_load | w_opimm | w_auipc | w_store | w_op | w_lui |
                      w_branch | w_jalr | w_jal | w_system;

    assign w_is_mul    = w_op & f_ir_i[25] & ~w_fun3[2];
    assign w_is_div    = w_op & f_ir_i[25] & w_fun3[2];
    assign w_is_shift  = (w_opimm | (w_op & ~f_ir_i[25])) & (w_fun3[1:0] == 2'b01);
    assign w_div_undef = w_is_div & ~MULDIV_EN;

    assign w_rd_nz    = (w_rd != 5'd0);
    assign w_rd_write = ((w_op | w_opimm | w_jal | w_jalr | w_lui | w_auipc) & w_rd_nz & ~w_div_undef) |
                        (w_system & w_rd_nz & (w_fun3 != 3'b000));
    // Loads retire through the memory writeback path, so x_rd_write stays 0 for them,
    // but they still own rd in the scoreboard until their data is forwardable.
    assign w_sb_write = w_rd_write | (w_load & w_rd_nz);

    assign w_use1 = w_op | w_opimm | w_load | w_store | w_branch | w_jalr | (w_system & ~w_fun3[2]);
    assign w_use2 = w_op | w_store | w_branch;

    // cnt[0] is only ever reset, so x0 can never raise a hazard.
    assign w_hazard   = f_valid_i & ~d_kill_i &
                        ((w_use1 & (r_cnt[w_rs1] != '0)) | (w_use2 & (r_cnt[w_rs2] != '0)));
    assign w_issue    = f_valid_i & ~w_hazard;
    assign w_cnt_load = w_issue & ~d_kill_i & w_sb_write & (w_lat != '0);

    assign d_stall_req_o = w_hazard;
    assign rf_rs1_o      = w_rs1;
    assign rf_rs2_o      = w_rs2;
    assign w_unused      = &{1'b0, f_ir_i[1:0], f_is_compressed_i};

    // Producer latency for the instruction in the decode slot.
    always_comb begin
        w_lat = '0;
        if (w_load)                      w_lat = C_LOAD;
        else if (w_is_shift)             w_lat = C_SHIFT;
        else if (w_is_mul)               w_lat = C_MUL;
        else if (w_is_div && MULDIV_EN)  w_lat = C_DIV;
    end

    // Result source select for the X stage.
    always_comb begin
        w_src = SRC_ALU;
        if (w_system)                    w_src = SRC_CSR;
        else if (w_is_shift)             w_src = SRC_SHIFTER;
        else if (w_is_mul)               w_src = SRC_MULTIPLY;
        else if (w_is_div && MULDIV_EN)  w_src = SRC_DIVIDE;
    end

    // Immediate by instruction format; opcodes without one get 0.
    always_comb begin
        w_imm = '0;
        if (w_opimm || w_load || w_jalr)
            w_imm = {{20{f_ir_i[31]}}, f_ir_i[31:20]};
        else if (w_store)
            w_imm = {{20{f_ir_i[31]}}, f_ir_i[31:25], f_ir_i[11:7]};
        else if (w_branch)
            w_imm = {{19{f_ir_i[31]}}, f_ir_i[31], f_ir_i[7], f_ir_i[30:25], f_ir_i[11:8], 1'b0};
        else if (w_lui || w_auipc)
            w_imm = {f_ir_i[31:12], 12'b0};
        else if (w_jal)
            w_imm = {{11{f_ir_i[31]}}, f_ir_i[31], f_ir_i[19:12], f_ir_i[20], f_ir_i[30:21], 1'b0};
    end

    // Busy view of the scoreboard for debug/trace.
    always_comb begin
        w_sb_busy = '0;
        for (int r = 0; r < 32; r++) w_sb_busy[r] = (r_cnt[r] != '0);
    end

    // Scoreboard counters: step down while the stage moves; a new load wins over the step.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int r = 0; r < 32; r++) r_cnt[r] <= '0;
        end else if (!d_stall_i) begin
            for (int r = 1; r < 32; r++) begin
                if (w_cnt_load && (w_rd == 5'(r)))
                    r_cnt[r] <= w_lat;
                else if (r_cnt[r] != '0)
                    r_cnt[r] <= r_cnt[r] - 1'b1;
            end
        end
    end

    // Decode-to-X pipeline register: kill clears the slot, stall holds it, hazard inserts a bubble.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_x_valid     <= 1'b0;
            r_x_pc        <= '0;
            r_x_rs1       <= '0;
            r_x_rs2       <= '0;
            r_x_rd        <= '0;
            r_x_opcode    <= '0;
            r_x_fun       <= '0;
            r_x_imm       <= '0;
            r_x_rd_write  <= 1'b0;
            r_x_is_load   <= 1'b0;
            r_x_is_store  <= 1'b0;
            r_x_is_undef  <= 1'b0;
            r_x_rd_source <= '0;
        end else if (d_kill_i) begin
            r_x_valid    <= 1'b0;
            r_x_is_load  <= 1'b0;
            r_x_is_store <= 1'b0;
        end else if (!d_stall_i) begin
            r_x_valid     <= w_issue;
            r_x_pc        <= f_pc_i;
            r_x_rs1       <= w_rs1;
            r_x_rs2       <= w_rs2;
            r_x_rd        <= w_rd;
            r_x_opcode    <= w_opc;
            r_x_fun       <= (w_jal | w_jalr | w_lui | w_auipc) ? 3'b000 : w_fun3;
            r_x_imm       <= w_imm;
            r_x_rd_write  <= w_rd_write;
            r_x_is_load   <= w_issue & w_load;
            r_x_is_store  <= w_issue & w_store;
            r_x_is_undef  <= ~w_known | w_div_undef;
            r_x_rd_source <= w_src;
        end
    end

    assign x_valid_o     = r_x_valid;
    assign x_pc_o        = r_x_pc;
    assign x_rs1_o       = r_x_rs1;
    assign x_rs2_o       = r_x_rs2;
    assign x_rd_o        = r_x_rd;
    assign x_opcode_o    = r_x_opcode;
    assign x_fun_o       = r_x_fun;
    assign x_imm_o       = r_x_imm;
    assign x_rd_write_o  = r_x_rd_write;
    assign x_is_load_o   = r_x_is_load;
    assign x_is_store_o  = r_x_is_store;
    assign x_is_undef_o  = r_x_is_undef;
    assign x_rd_source_o = r_x_rd_source;
    assign sb_busy_o     = w_sb_busy;
endmodule

// File: tb/tb_urv_decode_sb.sv
// tb_urv_decode_sb: directed scenarios for urv_decode_sb with a queue of expected X-stage transactions.
// Latency: expects each issued instruction on x_* one edge after it is presented.
// Backpressure: exercises d_stall_i, d_kill_i and scoreboard bubbles.
module tb_urv_decode_sb;
    logic        clk_i = 1'b0, rst_i = 1'b1, d_stall_i = 1'b0, d_kill_i = 1'b0;
    logic        f_valid_i = 1'b0, f_is_compressed_i = 1'b0;
    logic [31:0] f_ir_i = 32'h13, f_pc_i = 32'h0;
    logic        d_stall_req_o, x_valid_o, x_rd_write_o, x_is_load_o, x_is_store_o, x_is_undef_o;
    logic [4:0]  rf_rs1_o, rf_rs2_o, x_rs1_o, x_rs2_o, x_rd_o, x_opcode_o;
    logic [2:0]  x_fun_o, x_rd_source_o;
    logic [31:0] x_pc_o, x_imm_o, sb_busy_o;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rs1, rs2, rd, opc;
        logic [2:0]  fun;
        logic [31:0] imm;
        logic        rdw, ld, st, ud;
        logic [2:0]  src;
    } exp_t;

    exp_t exp_q[$];
    exp_t got, e;
    int   vectors = 0, miscompares = 0;
    logic adv_edge = 1'b0;

    localparam logic [6:0] LOAD = 7'b0000011, OPIMM = 7'b0010011, OP = 7'b0110011;

    urv_decode_sb dut (
        .clk_i(clk_i), .rst_i(rst_i), .d_stall_i(d_stall_i), .d_kill_i(d_kill_i),
        .d_stall_req_o(d_stall_req_o), .f_ir_i(f_ir_i), .f_pc_i(f_pc_i), .f_valid_i(f_valid_i),
        .f_is_compressed_i(f_is_compressed_i), .rf_rs1_o(rf_rs1_o), .rf_rs2_o(rf_rs2_o),
        .x_valid_o(x_valid_o), .x_pc_o(x_pc_o), .x_rs1_o(x_rs1_o), .x_rs2_o(x_rs2_o),
        .x_rd_o(x_rd_o), .x_opcode_o(x_opcode_o), .x_fun_o(x_fun_o), .x_imm_o(x_imm_o),
        .x_rd_write_o(x_rd_write_o), .x_is_load_o(x_is_load_o), .x_is_store_o(x_is_store_o),
        .x_is_undef_o(x_is_undef_o), .x_rd_source_o(x_rd_source_o), .sb_busy_o(sb_busy_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, rs1,
                                          input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] opc);
        return {f7, rs2, rs1, f3, rd, opc};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] opc);
        return {imm, rs1, f3, rd, opc};
    endfunction

    function automatic exp_t mk(input logic [31:0] pc, ir, input logic [2:0] fun, input logic [31:0] imm,
                                input logic rdw, ld, st, ud, input logic [2:0] src);
        exp_t x;
        x.pc = pc; x.rs1 = ir[19:15]; x.rs2 = ir[24:20]; x.rd = ir[11:7]; x.opc = ir[6:2];
        x.fun = fun; x.imm = imm; x.rdw = rdw; x.ld = ld; x.st = st; x.ud = ud; x.src = src;
        return x;
    endfunction

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic [31:0] ir, input logic [31:0] pc);
        f_ir_i = ir; f_pc_i = pc; f_valid_i = 1'b1;
    endtask

    task automatic idle;
        f_valid_i = 1'b0; f_ir_i = 32'h13;
    endtask

    // Records whether the edge just taken could move a new instruction into X.
    always @(posedge clk_i) adv_edge <= !d_stall_i && !rst_i;

    // Scoreboard: every newly issued X-stage slot must match the oldest outstanding expectation.
    always @(negedge clk_i) begin
        if (adv_edge && x_valid_o) begin
            got = {x_pc_o, x_rs1_o, x_rs2_o, x_rd_o, x_opcode_o, x_fun_o, x_imm_o,
                   x_rd_write_o, x_is_load_o, x_is_store_o, x_is_undef_o, x_rd_source_o};
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_issue got pc=%h (nothing expected)", x_pc_o);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    miscompares++;
                    $display("FAIL x_fields pc=%h got %h want %h", e.pc, got, e);
                end
            end
        end
    end

    task automatic test_reset;
        drive(enc_i(12'h0, 5'd1, 3'b010, 5'd5, LOAD), 32'hDEAD_BEE0);
        tick; tick;
        vectors++; if (x_valid_o !== 1'b0) begin miscompares++; $display("FAIL rst_valid got %b want 0", x_valid_o); end
        vectors++; if (x_pc_o !== 32'h0) begin miscompares++; $display("FAIL rst_pc got %h want 0", x_pc_o); end
        vectors++; if (sb_busy_o !== 32'h0) begin miscompares++; $display("FAIL rst_busy got %h want 0", sb_busy_o); end
        vectors++;
        if ({x_rs1_o, x_rs2_o, x_rd_o, x_opcode_o, x_fun_o, x_imm_o, x_rd_write_o, x_is_load_o,
             x_is_store_o, x_is_undef_o, x_rd_source_o} !== '0) begin
            miscompares++; $display("FAIL rst_fields got nonzero imm=%h rd=%h want all 0", x_imm_o, x_rd_o);
        end
        idle(); rst_i = 1'b0;
        tick;
    endtask

    task automatic test_load_use;
        logic [31:0] lw, add;
        lw  = enc_i(12'h0, 5'd1, 3'b010, 5'd5, LOAD);
        add = enc_r(7'h0, 5'd1, 5'd5, 3'b000, 5'd6, OP);
        drive(lw, 32'h100); exp_q.push_back(mk(32'h100, lw, 3'b010, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0));
        tick;
        drive(add, 32'h104); exp_q.push_back(mk(32'h104, add, 3'b000, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0));
        #1;
        vectors++; if (sb_busy_o !== 32'h20) begin miscompares++; $display("FAIL lu_busy got %h want 20", sb_busy_o); end
        vectors++; if (rf_rs1_o !== 5'd5) begin miscompares++; $display("FAIL lu_rf_rs1 got %0d want 5", rf_rs1_o); end
        vectors++; if (d_stall_req_o !== 1'b1) begin miscompares++; $display("FAIL lu_stall_a got %b want 1", d_stall_req_o); end
        tick;
        vectors++; if (x_valid_o !== 1'b0) begin miscompares++; $display("FAIL lu_bubble_a got %b want 0", x_valid_o); end
        vectors++; if (x_is_load_o !== 1'b0) begin miscompares++; $display("FAIL lu_bubble_ld got %b want 0", x_is_load_o); end
        vectors++; if (d_stall_req_o !== 1'b1) begin miscompares++; $display("FAIL lu_stall_b got %b want 1", d_stall_req_o); end
        tick;
        vectors++; if (x_valid_o !== 1'b0) begin miscompares++; $display("FAIL lu_bubble_b got %b want 0", x_valid_o); end
        vectors++; if (d_stall_req_o !== 1'b0) begin miscompares++; $display("FAIL lu_stall_c got %b want 0", d_stall_req_o); end
        tick;
        vectors++; if (x_valid_o !== 1'b1) begin miscompares++; $display("FAIL lu_issue got %b want 1", x_valid_o); end
        idle(); tick;
    endtask

    task automatic test_shift_indep;
        logic [31:0] slli, addi;
        slli = enc_i(12'h003, 5'd2, 3'b001, 5'd7, OPIMM);
        addi = enc_i(12'h001, 5'd0, 3'b000, 5'd8, OPIMM);
        drive(slli, 32'h200); exp_q.push_back(mk(32'h200, slli, 3'b001, 32'h3, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1));
        tick;
        drive(addi, 32'h204); exp_q.push_back(mk(32'h204, addi, 3'b000, 32'h1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0));
        #1;
        vectors++; if (d_stall_req_o !== 1'b0) begin miscompares++; $display("FAIL sh_stall got %b want 0", d_stall_req_o); end
        vectors++; if (sb_busy_o !== 32'h80) begin miscompares++; $display("FAIL sh_busy got %h want 80", sb_busy_o); end
        tick;
        vectors++; if (x_valid_o !== 1'b1) begin miscompares++; $display("FAIL sh_issue got %b want 1", x_valid_o); end
        vectors++; if (sb_busy_o !== 32'h0) begin miscompares++; $display("FAIL sh_busy_clr got %h want 0", sb_busy_o); end
        idle(); tick;
    endtask

    task automatic test_stall_freeze;
        logic [31:0] lw, add;
        lw  = enc_i(12'h008, 5'd3, 3'b010, 5'd5, LOAD);
        add = enc_r(7'h0, 5'd5, 5'd5, 3'b000, 5'd6, OP);
        drive(lw, 32'h300); exp_q.push_back(mk(32'h300, lw, 3'b010, 32'h8, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0));
        tick;
        idle(); d_stall_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick;
            vectors++; if (x_valid_o !== 1'b1 || x_pc_o !== 32'h300) begin
                miscompares++; $display("FAIL stall_hold%0d got v=%b pc=%h want v=1 pc=300", k, x_valid_o, x_pc_o); end
            vectors++; if (sb_busy_o !== 32'h20) begin miscompares++; $display("FAIL stall_busy%0d got %h want 20", k, sb_busy_o); end
        end
        d_stall_i = 1'b0;
        drive(add, 32'h304); exp_q.push_back(mk(32'h304, add, 3'b000, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0));
        #1;
        vectors++; if (d_stall_req_o !== 1'b1) begin miscompares++; $display("FAIL stall_cnt2 got %b want 1", d_stall_req_o); end
        tick;
        vectors++; if (d_stall_req_o !== 1'b1) begin miscompares++; $display("FAIL stall_cnt1 got %b want 1", d_stall_req_o); end
        tick;
        vectors++; if (d_stall_req_o !== 1'b0) begin miscompares++; $display("FAIL stall_cnt0 got %b want 0", d_stall_req_o); end
        tick;
        vectors++; if (x_valid_o !== 1'b1) begin miscompares++; $display("FAIL stall_issue got %b want 1", x_valid_o); end
        idle(); tick;
    endtask

    task automatic test_kill;
        logic [31:0] lw, add, lw10;
        lw   = enc_i(12'h0, 5'd1, 3'b010, 5'd5, LOAD);
        add  = enc_r(7'h0, 5'd1, 5'd5, 3'b000, 5'd6, OP);
        lw10 = enc_i(12'h0, 5'd0, 3'b010, 5'd10, LOAD);
        drive(lw, 32'h400); exp_q.push_back(mk(32'h400, lw, 3'b010, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0));
        tick;
        drive(add, 32'h404); exp_q.push_back(mk(32'h404, add, 3'b000, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0));
        d_kill_i = 1'b1;
        #1;
        vectors++; if (d_stall_req_o !== 1'b0) begin miscompares++; $display("FAIL kill_stall got %b want 0", d_stall_req_o); end
        tick;
        d_kill_i = 1'b0;
        vectors++; if (x_valid_o !== 1'b0) begin miscompares++; $display("FAIL kill_valid got %b want 0", x_valid_o); end
        #1;
        vectors++; if (d_stall_req_o !== 1'b1) begin miscompares++; $display("FAIL kill_cnt1 got %b want 1", d_stall_req_o); end
        tick;
        vectors++; if (d_stall_req_o !== 1'b0) begin miscompares++; $display("FAIL kill_cnt0 got %b want 0", d_stall_req_o); end
        tick;
        vectors++; if (x_valid_o !== 1'b1) begin miscompares++; $display("FAIL kill_issue got %b want 1", x_valid_o); end
        drive(lw10, 32'h408); d_kill_i = 1'b1;
        tick;
        d_kill_i = 1'b0; idle();
        vectors++; if (sb_busy_o !== 32'h0 || x_valid_o !== 1'b0) begin
            miscompares++; $display("FAIL kill_noload got busy=%h v=%b want busy=0 v=0", sb_busy_o, x_valid_o); end
        tick;
    endtask

    task automatic test_mul;
        logic [31:0] mul, add;
        mul = enc_r(7'h01, 5'd3, 5'd2, 3'b000, 5'd11, OP);
        add = enc_r(7'h0, 5'd0, 5'd11, 3'b000, 5'd12, OP);
        drive(mul, 32'h900); exp_q.push_back(mk(32'h900, mul, 3'b000, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd2));
        tick;
        drive(add, 32'h904); exp_q.push_back(mk(32'h904, add, 3'b000, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0));
        #1;
        vectors++; if (d_stall_req_o !== 1'b1) begin miscompares++; $display("FAIL mul_stall got %b want 1", d_stall_req_o); end
        tick;
        vectors++; if (x_valid_o !== 1'b0 || d_stall_req_o !== 1'b0) begin
            miscompares++; $display("FAIL mul_bubble got v=%b req=%b want 0 0", x_valid_o, d_stall_req_o); end
        tick;
        vectors++; if (x_valid_o !== 1'b1) begin miscompares++; $display("FAIL mul_issue got %b want 1", x_valid_o); end
        idle(); tick;
    endtask

    task automatic test_div;
        logic [31:0] divu, add;
        divu = enc_r(7'h01, 5'd3, 5'd2, 3'b101, 5'd9, OP);
        add  = enc_r(7'h0, 5'd9, 5'd9, 3'b000, 5'd1, OP);
`ifdef URV_DECODE_MULDIV_EN
        drive(divu, 32'h500); exp_q.push_back(mk(32'h500, divu, 3'b101, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd4));
        tick;
        drive(add, 32'h504); exp_q.push_back(mk(32'h504, add, 3'b000, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0));
        #1;
        for (int k = 0; k < 4; k++) begin
            vectors++; if (d_stall_req_o !== 1'b1) begin miscompares++; $display("FAIL div_stall%0d got %b want 1", k, d_stall_req_o); end
            tick;
            vectors++; if (x_valid_o !== 1'b0) begin miscompares++; $display("FAIL div_bubble%0d got %b want 0", k, x_valid_o); end
        end
`else
        drive(divu, 32'h500); exp_q.push_back(mk(32'h500, divu, 3'b101, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0));
        tick;
        drive(add, 32'h504); exp_q.push_back(mk(32'h504, add, 3'b000, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0));
        #1;
`endif
        vectors++; if (d_stall_req_o !== 1'b0 || sb_busy_o !== 32'h0) begin
            miscompares++; $display("FAIL div_free got req=%b busy=%h want 0 0", d_stall_req_o, sb_busy_o); end
        tick;
        vectors++; if (x_valid_o !== 1'b1) begin miscompares++; $display("FAIL div_issue got %b want 1", x_valid_o); end
        idle(); tick;
    endtask

    task automatic test_overwrite;
        logic [31:0] slli, lw, add;
        slli = enc_i(12'h001, 5'd2, 3'b001, 5'd13, OPIMM);
        lw   = enc_i(12'h0, 5'd1, 3'b010, 5'd13, LOAD);
        add  = enc_r(7'h0, 5'd0, 5'd13, 3'b000, 5'd14, OP);
        drive(slli, 32'h800); exp_q.push_back(mk(32'h800, slli, 3'b001, 32'h1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1));
        tick;
        drive(lw, 32'h804); exp_q.push_back(mk(32'h804, lw, 3'b010, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0));
        #1;
        vectors++; if (d_stall_req_o !== 1'b0) begin miscompares++; $display("FAIL ow_nostall got %b want 0", d_stall_req_o); end
        tick;
        drive(add, 32'h808); exp_q.push_back(mk(32'h808, add, 3'b000, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0));
        #1;
        vectors++; if (d_stall_req_o !== 1'b1) begin miscompares++; $display("FAIL ow_stall_a got %b want 1", d_stall_req_o); end
        tick;
        vectors++; if (d_stall_req_o !== 1'b1) begin miscompares++; $display("FAIL ow_stall_b got %b want 1", d_stall_req_o); end
        tick;
        vectors++; if (d_stall_req_o !== 1'b0) begin miscompares++; $display("FAIL ow_stall_c got %b want 0", d_stall_req_o); end
        tick;
        vectors++; if (x_valid_o !== 1'b1) begin miscompares++; $display("FAIL ow_issue got %b want 1", x_valid_o); end
        idle(); tick;
    endtask

    task automatic test_back_to_back;
        logic [31:0] sw, lui, beq;
        sw  = {7'b1111111, 5'd4, 5'd2, 3'b010, 5'b11100, 7'b0100011};
        lui = {20'h12345, 5'd3, 7'b0110111};
        beq = {1'b1, 6'b111111, 5'd2, 5'd1, 3'b000, 4'b1000, 1'b1, 7'b1100011};
        drive(sw, 32'hA00);  exp_q.push_back(mk(32'hA00, sw, 3'b010, 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0));
        tick;
        vectors++; if (x_valid_o !== 1'b1 || x_is_store_o !== 1'b1) begin
            miscompares++; $display("FAIL b2b_sw got v=%b st=%b want 1 1", x_valid_o, x_is_store_o); end
        drive(lui, 32'hA04); exp_q.push_back(mk(32'hA04, lui, 3'b000, 32'h1234_5000, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0));
        tick;
        vectors++; if (x_valid_o !== 1'b1) begin miscompares++; $display("FAIL b2b_lui got %b want 1", x_valid_o); end
        drive(beq, 32'hA08); exp_q.push_back(mk(32'hA08, beq, 3'b000, 32'hFFFF_FFF0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0));
        tick;
        vectors++; if (x_valid_o !== 1'b1) begin miscompares++; $display("FAIL b2b_beq got %b want 1", x_valid_o); end
        idle(); tick;
    endtask

    task automatic test_reset_mid;
        logic [31:0] lw, add;
        lw  = enc_i(12'h0, 5'd1, 3'b010, 5'd5, LOAD);
        add = enc_r(7'h0, 5'd1, 5'd5, 3'b000, 5'd6, OP);
        drive(lw, 32'h700); exp_q.push_back(mk(32'h700, lw, 3'b010, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0));
        tick;
        idle(); d_stall_i = 1'b1; rst_i = 1'b1;
        tick;
        vectors++; if (sb_busy_o !== 32'h0) begin miscompares++; $display("FAIL rmid_busy got %h want 0", sb_busy_o); end
        vectors++; if (x_valid_o !== 1'b0 || x_pc_o !== 32'h0) begin
            miscompares++; $display("FAIL rmid_x got v=%b pc=%h want 0 0", x_valid_o, x_pc_o); end
        rst_i = 1'b0; d_stall_i = 1'b0;
        drive(add, 32'h704); exp_q.push_back(mk(32'h704, add, 3'b000, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0));
        #1;
        vectors++; if (d_stall_req_o !== 1'b0) begin miscompares++; $display("FAIL rmid_stall got %b want 0", d_stall_req_o); end
        tick;
        vectors++; if (x_valid_o !== 1'b1) begin miscompares++; $display("FAIL rmid_issue got %b want 1", x_valid_o); end
        idle(); tick; tick;
    endtask

    task automatic test_drain;
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++; $display("FAIL drain got %0d outstanding want 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_shift_indep();
        test_stall_freeze();
        test_kill();
        test_mul();
        test_div();
        test_overwrite();
        test_back_to_back();
        test_reset_mid();
        test_drain();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
